// File: rtl/sram_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_axi_pkg
// Description : Shared types and constants for the SRAM-to-AXI arbiter:
//               FSM state encoding, AXI ID values and fixed burst attributes.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_axi_pkg;

  // One transaction in flight; the FSM walks a read or a write path.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    R    = 3'd2,
    AW_W = 3'd3,
    B    = 3'd4
  } state_t;

  // AXI ID tags identifying the requesting port.
  localparam logic [3:0] ID_INST = 4'd0;
  localparam logic [3:0] ID_DATA = 4'd1;

  // Every transfer is a single 32-bit INCR beat.
  localparam logic [7:0] AXI_LEN        = 8'd0;
  localparam logic [2:0] AXI_SIZE       = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // Bit positions inside the one-hot grant vector.
  localparam int GRANT_INST = 0;
  localparam int GRANT_DATA = 1;

endpackage
`default_nettype wire

// File: rtl/sram_axi_grant.sv
`default_nettype none
// ============================================================================
// Module      : sram_axi_grant
// Description : Two-way grant between instruction and data requests.
//               Returns a one-hot grant (bit 0 = inst, bit 1 = data).
//               ARB_ROUND_ROBIN_EN defined   : round-robin on collisions.
//               ARB_ROUND_ROBIN_EN undefined : data always beats inst.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_axi_grant
  import sram_axi_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
  input  logic       clk,
  input  logic       resetn,
  input  logic       update,
`endif
  input  logic       inst_req,
  input  logic       data_req,
  output logic [1:0] grant
);

`ifdef ARB_ROUND_ROBIN_EN
  // Winner of the most recent collision: 0 = inst, 1 = data.
  logic last_grant;

  // Only contested grants move the pointer, so a repeated collision
  // hands the bus to the port that lost the previous one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant <= 1'b0;
    end else if (update && inst_req && data_req) begin
      last_grant <= grant[GRANT_DATA];
    end
  end

  // Collision goes to the port not granted last time.
  always_comb begin
    grant = 2'b00;
    if (inst_req && data_req) begin
      grant[GRANT_DATA] = ~last_grant;
      grant[GRANT_INST] = last_grant;
    end else begin
      grant[GRANT_DATA] = data_req;
      grant[GRANT_INST] = inst_req;
    end
  end
`else
  // Fixed priority: a data request always masks the instruction request.
  always_comb begin
    grant             = 2'b00;
    grant[GRANT_DATA] = data_req;
    grant[GRANT_INST] = inst_req & ~data_req;
  end
`endif

endmodule
`default_nettype wire

// File: rtl/sram_axi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_axi_arbiter
// Description : Shares one single-beat AXI master between the instruction
//               (read-only) and data (read/write) SRAM-like ports. Exactly one
//               transaction is outstanding at a time.
//               Optional macro ARB_ROUND_ROBIN_EN selects round-robin grant.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_axi_arbiter (
  input  logic        clk,
  input  logic        resetn,
  // instruction port
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data port
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // AXI read address / data
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  // AXI write address / data / response
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);
  import sram_axi_pkg::*;

  state_t     state;
  logic       src_data;   // 1 when the in-flight transaction belongs to the data port
  logic       aw_done;
  logic       w_done;
  logic [1:0] grant;
  logic       idle;
  logic       aw_fire;
  logic       w_fire;
  logic       aw_all;
  logic       w_all;

  // Acceptance is only possible in IDLE and never while reset is held.
  assign idle         = (state == IDLE) && resetn;
  assign inst_addr_ok = idle && grant[GRANT_INST];
  assign data_addr_ok = idle && grant[GRANT_DATA];

  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;
  assign aw_all  = aw_done || aw_fire;
  assign w_all   = w_done || w_fire;

  sram_axi_grant u_grant (
`ifdef ARB_ROUND_ROBIN_EN
    .clk      (clk),
    .resetn   (resetn),
    .update   (idle),
`endif
    .inst_req (inst_req),
    .data_req (data_req),
    .grant    (grant)
  );

  // Transaction sequencer: latches the granted request and walks AR/R or AW+W/B.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      src_data     <= 1'b0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      arvalid      <= 1'b0;
      rready       <= 1'b0;
      awvalid      <= 1'b0;
      wvalid       <= 1'b0;
      bready       <= 1'b0;
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      inst_rdata   <= 32'd0;
      data_rdata   <= 32'd0;
      arid         <= ID_INST;
      araddr       <= 32'd0;
      awaddr       <= 32'd0;
      wdata        <= 32'd0;
      wstrb        <= 4'd0;
    end else begin
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      case (state)
        IDLE: begin
          if (grant[GRANT_DATA]) begin
            src_data <= 1'b1;
            if (data_wr) begin
              awaddr  <= data_addr;
              wdata   <= data_wdata;
              wstrb   <= data_wstrb;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
              state   <= AW_W;
            end else begin
              araddr  <= data_addr;
              arid    <= ID_DATA;
              arvalid <= 1'b1;
              state   <= AR;
            end
          end else if (grant[GRANT_INST]) begin
            src_data <= 1'b0;
            araddr   <= inst_addr;
            arid     <= ID_INST;
            arvalid  <= 1'b1;
            state    <= AR;
          end
        end
        AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= R;
          end
        end
        R: begin
          if (rvalid) begin
            rready <= 1'b0;
            if (src_data) begin
              data_rdata   <= rdata;
              data_data_ok <= 1'b1;
            end else begin
              inst_rdata   <= rdata;
              inst_data_ok <= 1'b1;
            end
            state <= IDLE;
          end
        end
        AW_W: begin
          if (aw_fire) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_fire) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if (aw_all && w_all) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            bready  <= 1'b1;
            state   <= B;
          end
        end
        B: begin
          if (bvalid) begin
            bready       <= 1'b0;
            data_data_ok <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_axi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_axi_arbiter
// Description : Self-checking bench for sram_axi_arbiter with a transaction-
//               level reference model, a delay-programmable AXI slave and
//               randomized requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_axi_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_req = 1'b0, data_req = 1'b0, data_wr = 1'b0;
  logic [31:0] inst_addr = '0, data_addr = '0, data_wdata = '0;
  logic [3:0]  data_wstrb = '0;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic [3:0]  arid, wstrb;
  logic [31:0] araddr, awaddr, wdata;
  logic        arvalid, rready, awvalid, wvalid, bready;
  logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [31:0] rdata = '0;

  always #5 clk = ~clk;

  sram_axi_arbiter dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  bit          busy, ar_pend, r_pend, aw_pend, w_pend, b_pend;
  bit          cur_data, cur_wr;
  logic [31:0] cur_addr, cur_wdata;
  logic [3:0]  cur_wstrb;
  bit          exp_idok, exp_ddok;
  logic [31:0] exp_irdata, exp_drdata;
  bit          last_data;
  bit          inst_acc, data_acc;
  bit          pick_d, exp_iaok, exp_daok;

  // Compare the DUT against the model each cycle, then advance the model
  // by what the coming clock edge will do.
  always @(negedge clk) begin
    if (!resetn) begin
      busy = 0; ar_pend = 0; r_pend = 0; aw_pend = 0; w_pend = 0; b_pend = 0;
      exp_idok = 0; exp_ddok = 0; exp_irdata = '0; exp_drdata = '0;
      last_data = 0; inst_acc = 0; data_acc = 0;
      chk("rst_ctrl", {arvalid, rready, awvalid, wvalid, bready, inst_addr_ok,
                       data_addr_ok, inst_data_ok, data_data_ok}, '0);
      chk("rst_rdata", {inst_rdata, data_rdata}, '0);
      chk("rst_addr", {araddr, awaddr}, '0);
      chk("rst_w", {wdata, wstrb, arid}, '0);
    end else begin
      pick_d   = data_req && !(RR_MODE && inst_req && last_data);
      exp_iaok = !busy && inst_req && !pick_d;
      exp_daok = !busy && pick_d;
      chk("addr_ok", {inst_addr_ok, data_addr_ok}, {exp_iaok, exp_daok});
      chk("valids", {arvalid, rready, awvalid, wvalid, bready},
          {ar_pend, r_pend, aw_pend, w_pend, b_pend});
      chk("data_ok", {inst_data_ok, data_data_ok}, {exp_idok, exp_ddok});
      chk("inst_rdata", inst_rdata, exp_irdata);
      chk("data_rdata", data_rdata, exp_drdata);
      if (ar_pend) chk("ar_addr_id", {arid, araddr}, {3'd0, cur_data, cur_addr});
      if (aw_pend) chk("awaddr", awaddr, cur_addr);
      if (w_pend)  chk("w_data_strb", {wstrb, wdata}, {cur_wstrb, cur_wdata});

      exp_idok = 0; exp_ddok = 0; inst_acc = 0; data_acc = 0;
      if (busy) begin
        if (ar_pend) begin
          if (arready) begin ar_pend = 0; r_pend = 1; end
        end else if (r_pend) begin
          if (rvalid) begin
            r_pend = 0; busy = 0;
            if (cur_data) begin exp_ddok = 1; exp_drdata = rdata; end
            else begin exp_idok = 1; exp_irdata = rdata; end
          end
        end else if (aw_pend || w_pend) begin
          if (awready) aw_pend = 0;
          if (wready) w_pend = 0;
          if (!aw_pend && !w_pend) b_pend = 1;
        end else if (b_pend && bvalid) begin
          b_pend = 0; busy = 0; exp_ddok = 1;
        end
      end else if (exp_iaok || exp_daok) begin
        if (inst_req && data_req) last_data = exp_daok;
        busy      = 1;
        cur_data  = exp_daok;
        cur_wr    = exp_daok && data_wr;
        cur_addr  = exp_daok ? data_addr : inst_addr;
        cur_wdata = data_wdata;
        cur_wstrb = data_wstrb;
        if (cur_wr) begin aw_pend = 1; w_pend = 1; end
        else ar_pend = 1;
        inst_acc = exp_iaok;
        data_acc = exp_daok;
      end
    end
  end

  // ---------------- stimulus: slave + requesters ----------------
  bit          rand_dly = 0, rand_req = 0;
  int          dly_ar = 0, dly_r = 0, dly_aw = 0, dly_w = 0, dly_b = 0;
  int          ar_age = 0, r_age = 0, aw_age = 0, w_age = 0, b_age = 0;
  logic [31:0] rdata_fix = '0;

  task automatic step();
    @(posedge clk);
    #2;
    ar_age = ar_pend ? ar_age + 1 : 0;
    r_age  = r_pend  ? r_age + 1  : 0;
    aw_age = aw_pend ? aw_age + 1 : 0;
    w_age  = w_pend  ? w_age + 1  : 0;
    b_age  = b_pend  ? b_age + 1  : 0;
    if (rand_dly) begin
      if (ar_age == 1) dly_ar = $urandom_range(0, 3);
      if (r_age == 1)  dly_r  = $urandom_range(0, 3);
      if (aw_age == 1) dly_aw = $urandom_range(0, 3);
      if (w_age == 1)  dly_w  = $urandom_range(0, 3);
      if (b_age == 1)  dly_b  = $urandom_range(0, 3);
    end
    arready = ar_pend && (ar_age > dly_ar);
    rvalid  = r_pend  && (r_age > dly_r);
    awready = aw_pend && (aw_age > dly_aw);
    wready  = w_pend  && (w_age > dly_w);
    bvalid  = b_pend  && (b_age > dly_b);
    rdata   = rand_dly ? $urandom : rdata_fix;
    if (inst_acc) inst_req = 0;
    if (data_acc) data_req = 0;
    if (rand_req) begin
      if (!inst_req && $urandom_range(0, 2) == 0) begin
        inst_req  = 1;
        inst_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!data_req && $urandom_range(0, 2) == 0) begin
        data_req   = 1;
        data_wr    = 1'($urandom_range(0, 1));
        data_addr  = $urandom;
        data_wdata = $urandom;
        data_wstrb = 4'($urandom_range(0, 15));
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || inst_req || data_req) && n < 200) begin
      step();
      n++;
    end
    chk("idle_timeout", n < 200, 1);
  endtask

  task automatic set_dly(input int ar, input int r, input int aw, input int w, input int b);
    dly_ar = ar; dly_r = r; dly_aw = aw; dly_w = w; dly_b = b;
  endtask

  initial begin
    int cnt_aw, cnt_w, cnt_ok, k;
    bit got;
    repeat (3) step();
    resetn = 1;

    // Instruction read, zero-wait slave.
    set_dly(0, 0, 0, 0, 0);
    rdata_fix = 32'h3C08BFAF;
    step();
    inst_req = 1; inst_addr = 32'h1FC0_0000;
    #1 chk("t1_addr_ok_T0", inst_addr_ok, 1);
    step(); #1 chk("t1_ar_T1", {arvalid, arid, araddr}, {1'b1, 4'd0, 32'h1FC0_0000});
    step();
    step(); #1 chk("t1_data_ok_T3", {inst_data_ok, inst_rdata}, {1'b1, 32'h3C08BFAF});
    wait_idle();

    // Simultaneous inst/data reads.
    rdata_fix = 32'h1234_5678;
    for (int rep = 0; rep < 2; rep++) begin
      step();
      inst_req = 1; inst_addr = 32'h100;
      data_req = 1; data_wr = 0; data_addr = 32'h200;
      #1;
      if (rep == 0) chk("col_grant_first", {inst_addr_ok, data_addr_ok}, 2'b01);
      else chk("col_grant_repeat", {inst_addr_ok, data_addr_ok}, RR_MODE ? 2'b10 : 2'b01);
      step();
      if (rep == 0) begin
        #1 chk("col_ar_data", {arid, araddr}, {4'd1, 32'h200});
        got = 0;
        for (k = 0; k < 20; k++) begin
          step(); #1;
          if (inst_addr_ok) begin got = 1; break; end
        end
        chk("col_inst_b2b", {got, data_data_ok}, 2'b11);
        step(); #1 chk("col_ar_inst", {arid, araddr}, {4'd0, 32'h100});
      end
      wait_idle();
    end

    // Write with wready two cycles ahead of awready.
    set_dly(0, 0, 2, 0, 1);
    step();
    data_req = 1; data_wr = 1; data_addr = 32'h8000_0010;
    data_wdata = 32'hDEADBEEF; data_wstrb = 4'b0011;
    cnt_aw = 0; cnt_w = 0; cnt_ok = 0;
    repeat (15) begin
      step(); #1;
      cnt_aw += int'(awvalid && awready);
      cnt_w  += int'(wvalid && wready);
      cnt_ok += int'(data_data_ok);
    end
    chk("wr_handshakes", {cnt_aw[7:0], cnt_w[7:0], cnt_ok[7:0]}, 24'h010101);
    wait_idle();

    // Slow read: 5-cycle arready, 3-cycle rvalid.
    set_dly(5, 3, 0, 0, 0);
    rdata_fix = 32'hCAFE_F00D;
    step();
    data_req = 1; data_wr = 0; data_addr = 32'h0000_0A40;
    cnt_ok = 0;
    repeat (20) begin
      step(); #1;
      cnt_ok += int'(data_data_ok);
    end
    chk("slow_rd", {cnt_ok[7:0], data_rdata}, {8'd1, 32'hCAFE_F00D});
    wait_idle();

    // Reset while waiting in R.
    set_dly(0, 10, 0, 0, 0);
    step();
    inst_req = 1; inst_addr = 32'h40;
    got = 0;
    for (k = 0; k < 10; k++) begin
      step(); #1;
      if (rready) begin got = 1; break; end
    end
    chk("rst_reach_r", got, 1);
    step();
    resetn = 0;
    #1 chk("rst_mid_txn", {arvalid, rready, inst_data_ok, inst_addr_ok}, 4'b0000);
    step();
    step();
    resetn = 1;
    cnt_ok = 0;
    repeat (15) begin
      step(); #1;
      cnt_ok += int'(inst_data_ok || data_data_ok);
    end
    chk("rst_no_data_ok", cnt_ok, 0);
    wait_idle();

    // Randomized traffic against the model.
    rand_dly = 1;
    rand_req = 1;
    repeat (4000) step();
    rand_req = 0;
    wait_idle();
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
